// File: rtl/mem_pkg.sv
// Shared types and constants for the burst reader and its 16-entry memory.
package mem_pkg;

  localparam int unsigned MEM_AW     = 4;
  localparam int unsigned MEM_WORDS  = 16;
  localparam int unsigned MEM_RD_LAT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/rd_fifo.sv
// Synchronous FIFO with occupancy count; storage is cleared on reset.
module rd_fifo #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W:0]               din,
  input  logic                     pop,
  output logic [W:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Streams a wrapping burst of memory words out through a credit-limited FIFO.
module mem_burst_reader #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  base,
  input  logic [4:0]  len,
  output logic        busy,
  output logic        done,
  output logic [3:0]  mem_add,
  output logic        mem_en,
  input  logic [W:0]  mem_out,
  output logic [W:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready
);
  import mem_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned UW = CW + 1;

  state_e                state_q, state_d;
  logic [MEM_AW:0]       cnt_q, cnt_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic [MEM_RD_LAT-1:0] pend_q;

  logic          fifo_full, fifo_empty, pop, credit_ok;
  logic [CW-1:0] fifo_count;
  logic [UW-1:0] used;

  rd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pend_q[MEM_RD_LAT-1]),
    .din   (mem_out),
    .pop   (pop),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign dout_valid = !fifo_empty;
  assign pop        = dout_valid && dout_ready;

  // Buffered words plus every read still in the memory pipeline must fit the FIFO.
  assign used = UW'(fifo_count) + UW'($countones(pend_q)) + UW'(en_q);
  assign credit_ok = (used < UW'(DEPTH)) && !fifo_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base;
            en_d    = 1'b1;
            cnt_d   = len - (MEM_AW+1)'(1);
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (cnt_q == '0) begin
          state_d = StDrain;
        end else if (credit_ok) begin
          en_d   = 1'b1;
          addr_d = addr_q + MEM_AW'(1);
          cnt_d  = cnt_q - (MEM_AW+1)'(1);
        end
      end
      StDrain: begin
        // Finish on the edge that hands off the final beat.
        if (!en_q && (pend_q == '0) &&
            (fifo_empty || ((fifo_count == CW'(1)) && pop))) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      done_q    <= done_d;
      pend_q[0] <= en_q;
      for (int i = 1; i < int'(MEM_RD_LAT); i++) pend_q[i] <= pend_q[i-1];
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign mem_add = addr_q;
  assign mem_en  = en_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomised and directed bench for mem_burst_reader against a queue-based reference model.
module tb_mem_burst_reader;

  localparam int unsigned W     = 7;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base = '0;
  logic [4:0] len = '0;
  logic       busy, done, mem_en, dout_valid;
  logic [3:0] mem_add;
  logic [W:0] mem_out = '0;
  logic [W:0] dout;
  logic       dout_ready = 1'b0;

  logic [W:0] mem [16];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0, beats = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  int issued = 0, accepted = 0;
  int rmode = 0;
  int d0;
  logic [W:0] q[$];
  logic       exp_busy = 1'b0, exp_done = 1'b0;
  logic [3:0] exp_addr = '0;

  mem_burst_reader #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_add    (mem_add),
    .mem_en     (mem_en),
    .mem_out    (mem_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  // One-cycle-latency synchronous memory.
  always @(posedge clk) if (mem_en) mem_out <= mem[mem_add];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ~dout_ready;
      2:       dout_ready = 1'b0;
      default: dout_ready = (($urandom % 4) != 0);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: mid-cycle view of what the next edge will do.
  always @(negedge clk) begin
    logic nd, nb;
    logic [3:0] idx;
    if (reset) begin
      q.delete();
      exp_busy = 1'b0;
      exp_done = 1'b0;
      issued   = 0;
      accepted = 0;
    end else begin
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      if (done) done_cnt++;
      nd = 1'b0;
      nb = exp_busy;
      if (mem_en) begin
        chk("mem_add", mem_add, exp_addr);
        exp_addr = exp_addr + 4'd1;
        issued++;
        chk("credit", (issued - accepted) <= int'(DEPTH), 1);
      end
      if (dout_valid && q.size() == 0) chk("spurious_valid", 1, 0);
      if (dout_valid && dout_ready && q.size() != 0) begin
        chk("dout", dout, q.pop_front());
        accepted++;
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
        if (q.size() == 0 && exp_busy) begin
          nd = 1'b1;
          nb = 1'b0;
        end
      end
      if (start && !exp_busy) begin
        if (len == 0) begin
          nd = 1'b1;
        end else begin
          for (int i = 0; i < int'(len); i++) begin
            idx = base + i[3:0];
            q.push_back(mem[idx]);
          end
          nb       = 1'b1;
          exp_addr = base;
          issued   = 0;
          accepted = 0;
        end
      end
      exp_busy = nb;
      exp_done = nd;
    end
  end

  task automatic issue_burst(input logic [3:0] b, input logic [4:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_burst();
    int n = 0;
    while (exp_busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout", exp_busy, 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + i[7:0];
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_add", mem_add, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic burst, latency and throughput.
    d0 = done_cnt; beats = 0;
    issue_burst(4'd2, 5'd4);
    chk("t1_en", mem_en, 1);
    chk("t1_add", mem_add, 2);
    @(posedge clk); #1;
    chk("t1_valid_early", dout_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid", dout_valid, 1);
    chk("t1_dout0", dout, 8'h12);
    wait_burst();
    chk("t1_beats", beats, 4);
    chk("t1_span", last_cyc - first_cyc, 3);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // Address wrap, plus a start strobe while busy.
    d0 = done_cnt; beats = 0;
    issue_burst(4'd14, 5'd5);
    @(posedge clk); #1;
    start = 1'b1; base = 4'd7; len = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_burst();
    chk("t2_beats", beats, 5);
    chk("t2_done_pulses", done_cnt - d0, 1);

    // Full-length burst with toggling ready.
    rmode = 1; beats = 0;
    issue_burst(4'd0, 5'd16);
    wait_burst();
    chk("t3_beats", beats, 16);
    rmode = 0;

    // Zero-length command.
    d0 = done_cnt;
    issue_burst(4'd3, 5'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t4_en", mem_en, 0);
      chk("t4_busy", busy, 0);
    end
    chk("t4_done_pulses", done_cnt - d0, 1);

    // Reset after the third beat of a long burst.
    d0 = done_cnt; beats = 0;
    issue_burst(4'd0, 5'd8);
    for (int n = 0; n < 50 && beats < 3; n++) begin @(posedge clk); #1; end
    chk("t5_third_beat", beats, 3);
    reset = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_en", mem_en, 0);
    chk("t5_add", mem_add, 0);
    chk("t5_valid", dout_valid, 0);
    chk("t5_dout", dout, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_no_done", done_cnt - d0, 0);
    beats = 0;
    issue_burst(4'd5, 5'd2);
    wait_burst();
    chk("t5_new_beats", beats, 2);
    chk("t5_new_done", done_cnt - d0, 1);

    // Back-pressure at burst start.
    rmode = 2;
    @(posedge clk); #1;
    beats = 0;
    issue_burst(4'd0, 5'd8);
    repeat (10) begin @(posedge clk); #1; end
    chk("t6_stalled_en", mem_en, 0);
    chk("t6_outstanding", issued - accepted, DEPTH);
    chk("t6_no_beats", beats, 0);
    chk("t6_valid", dout_valid, 1);
    rmode = 0;
    wait_burst();
    chk("t6_beats", beats, 8);

    // Random bursts with random memory contents and random ready.
    rmode = 3;
    for (int k = 0; k < 30; k++) begin
      logic [3:0] b;
      logic [4:0] l;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      b = 4'($urandom % 16);
      l = 5'($urandom % 17);
      d0 = done_cnt; beats = 0;
      issue_burst(b, l);
      wait_burst();
      chk("rnd_beats", beats, l);
      chk("rnd_done_pulses", done_cnt - d0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read-side initiator for the 16-entry synchronous memory block. Accepts a burst command (start address, length), drives the memory's address/enable port with sequential addresses wrapping modulo 16, captures the memory's data output and presents each word on a valid/ready stream with back-pressure. Sits between the memory and any downstream consumer (checker, UART transmitter, DMA sink) that needs memory contents streamed out in order.

## Interface
- W, default 7: MSB index of the data bus; data width is W+1 bits.
- DEPTH, default 4: output FIFO depth in words; power of two, minimum 4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock, one reset.
- start  in  1  command strobe; sampled only while busy=0.
- base  in  4  first memory address of the burst.
- len  in  5  number of words, 0..16.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- mem_add  out  4  memory address, registered.
- mem_en  out  1  memory read enable, registered.
- mem_out  in  W+1  memory data; valid the cycle after an edge that samples mem_en=1.
- dout  out  W+1  stream data (FIFO head).
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready; a beat transfers on an edge where valid and ready are both 1.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: start=1 with len≥1 latches base/len, loads issue counter = len, goes to ISSUE, sets busy. start=1 with len=0 pulses done next cycle, stays IDLE, issues nothing. start is ignored while busy=1.
- ISSUE: each cycle, mem_en=1 when issue counter>0 and credits allow (FIFO occupancy + in-flight reads < DEPTH); mem_add then increments by 1 modulo 16 (15 wraps to 0). Issue counter hits 0 → DRAIN.
- In-flight tracking: a read issued in cycle c writes mem_out into the FIFO at the end of cycle c+1. In-flight count ≤ 2.
- DRAIN: wait until in-flight = 0 and FIFO empty with the last word accepted; pulse done, clear busy, return to IDLE.
- Simultaneous FIFO push and pop on one edge: occupancy unchanged; data order preserved.
- dout_ready held low: issuing stalls once credits run out; no word is ever dropped or duplicated.
- FIFO full never coincides with a push, because the credit check guarantees it.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_add=0, dout_valid=0, dout=0, state IDLE, FIFO empty, counters 0.
- Reset mid-burst: all of the above immediately (asynchronous). In-flight data is discarded and done is not pulsed.
- Latency: start sampled at edge E0 → mem_en=1, mem_add=base after E0 → memory output valid after E1 → dout_valid=1 after E2.
- Throughput: one word per cycle with dout_ready held high.
- done asserts the cycle after the edge that transfers the final beat.

## Structure
- Shared package mem_pkg: state enum, MEM_AW=4, MEM_WORDS=16, MEM_RD_LAT=1.
- Sub-module rd_fifo (parameters W, DEPTH): synchronous FIFO with push, pop, full, empty and count outputs, same clock and asynchronous reset. The top level holds the FSM, the address and issue counters, and the credit logic.

## Test plan
- Memory model preloaded with mem[i]=8'h10+i. base=2, len=4, ready held high → dout 12,13,14,15 on consecutive cycles; first valid 3 cycles after start; one done pulse.
- base=14, len=5 → mem_add sequence 14,15,0,1,2; dout 1E,1F,10,11,12.
- base=0, len=16, dout_ready toggling 1/0 each cycle → all 16 words in order, none lost or duplicated; mem_en never raised while occupancy + in-flight = 4.
- len=0 → done pulses once, mem_en stays 0, busy stays 0. Also, start pulsed while busy → ignored; beat count unchanged.
- reset asserted after the 3rd beat of a len=8 burst → all outputs 0 immediately; no done pulse. A new burst base=5, len=2 then returns 15,16.
- dout_ready held low for 10 cycles at burst start, then released → 4 words buffered, mem_en stalled, then the remaining words stream out in order.
